sram_like_arbiter: RTL and testbench
====================================

Name: sram_like_arbiter

Overview:
- Shares one SRAM-like master port between the instruction-fetch requester and the data-memory requester.
- The data requester is the load/store path whose byte enables and sizes come from the memory-stage formatter.
- Sits between the CPU core and the SRAM-like-to-AXI bridge.
- Grants one requester, latches its request, drives the single bus transaction, then routes the response back to the owner. At most one transaction is outstanding.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
inst_req  in  1  fetch request; held until inst_addr_ok
inst_addr  in  ADDR_W  fetch address
inst_addr_ok  out  1  fetch request accepted (1-cycle pulse)
inst_data_ok  out  1  fetch data valid (1-cycle pulse)
inst_rdata  out  DATA_W  fetch data
data_req  in  1  load/store request; held until data_addr_ok
data_wr  in  1  1 = store
data_size  in  2  0 = byte, 1 = half, 2 = word
data_addr  in  ADDR_W  load/store address
data_wdata  in  DATA_W  store data, already lane-replicated
data_addr_ok  out  1  load/store accepted (1-cycle pulse)
data_data_ok  out  1  load data valid / store done (1-cycle pulse)
data_rdata  out  DATA_W  load data
bus_req  out  1  bus request
bus_wr  out  1  bus write
bus_size  out  2  bus size
bus_addr  out  ADDR_W  bus address
bus_wdata  out  DATA_W  bus write data
bus_addr_ok  in  1  slave accepted the request
bus_data_ok  in  1  slave response valid
bus_rdata  in  DATA_W  slave read data

Behaviour:
- FSM states: IDLE, ADDR, DATA.
- Reset: state = IDLE, owner = INST, rr_last = INST. All registered outputs are 0: bus_req, bus_wr, bus_size, bus_addr, bus_wdata.
- IDLE, any request pending:
  - Choose the winner (default rule: data has priority).
  - Latch into bus_* registers:
    - Data win: wr, size, addr, wdata.
    - Inst win: wr = 0, size = 2, wdata = 0.
  - Record owner.
  - Pulse the winner's *_addr_ok in the same cycle, combinationally from state and requests.
  - Go to ADDR. The loser sees no addr_ok and keeps holding its request.
- IDLE, no request: stay in IDLE; bus_req = 0.
- ADDR:
  - bus_req = 1 and all bus_* fields are held stable.
  - bus_addr_ok = 1 → bus_req cleared at the next edge; go to DATA.
  - bus_addr_ok = 0 → hold; no timeout.
- DATA:
  - bus_req = 0.
  - On bus_data_ok = 1: owner's *_data_ok = 1 combinationally that cycle; go to IDLE.
  - The next grant can occur in the following IDLE cycle. Minimum per transaction: 3 cycles with zero-wait slave.
- Read data: inst_rdata and data_rdata are both wired directly to bus_rdata. Only the owner's data_ok qualifies it.
- Stores: the data_ok pulse means write complete. rdata is don't-care.
- bus_data_ok outside DATA is ignored; the slave never issues it. inst_data_ok and data_data_ok are never both 1.
- *_addr_ok occurs only in IDLE. Both *_addr_ok never assert in the same cycle.
- A requester dropping req without addr_ok is legal; it is simply not granted.
- Reset asserted mid-transaction: immediately returns to IDLE and zeroes outputs. The in-flight transaction is discarded; the bridge is reset by the same rst.

Optional Feature:
ARB_RR_EN:
- Defined: round-robin arbitration. On simultaneous requests in IDLE, grant the requester that is not rr_last, then update rr_last to the winner. A lone requester is always granted.
- Undefined: fixed priority, data over inst. The rr_last register is not present.

Test Plan:
- Idle, inst_req = 1, inst_addr = 0xBFC00000; slave gives addr_ok next cycle and data_ok with rdata = 0x3C08BFAF one cycle later → inst_addr_ok pulse in cycle 0; bus_req = 1, bus_size = 2 in cycle 1; inst_data_ok in cycle 2 with inst_rdata = 0x3C08BFAF.
- inst_req and data_req both 1 (LW at 0x80001000), fixed priority → data granted first. Inst is granted in the IDLE after data_data_ok; no addr_ok overlap.
- data SB: wr = 1, size = 0, addr = 0x80000003, wdata = 0x5A5A5A5A; slave holds addr_ok low for 4 cycles → bus_req stays 1 with stable fields for 4 cycles; data_data_ok after bus_data_ok.
- With ARB_RR_EN: both requesters continuously active for 4 transactions → grants alternate data, inst, data, inst.
- rst asserted while in DATA (waiting on bus_data_ok) → bus_req = 0 and state IDLE asynchronously; no data_ok pulse. After release, a new inst request completes normally.
- bus_data_ok glitch asserted in ADDR → ignored; FSM stays in ADDR and no *_data_ok pulse.

Source files
------------

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like master port between the
// instruction-fetch requester and the load/store requester.
// One transaction is outstanding at a time: IDLE grants and latches,
// ADDR presents bus_req until the slave accepts, and DATA waits for the
// response and routes it back to the owner.
// Optional build macro ARB_RR_EN: round-robin arbitration on simultaneous
// requests. Without it, data has fixed priority over inst.
//
// Handshake: a requester holds *_req until it sees its *_addr_ok pulse.
// *_addr_ok is a one-cycle pulse in IDLE. *_data_ok is a one-cycle pulse in
// DATA, and it qualifies *_rdata. On the bus side, bus_req is held with
// stable fields until bus_addr_ok. bus_data_ok is only honoured in DATA.
module sram_like_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_t            state_q;
  logic              owner_q;
  logic              bus_req_q;
  logic              bus_wr_q;
  logic [1:0]        bus_size_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;

  logic data_first;
  logic grant_data;
  logic grant_inst;

`ifdef ARB_RR_EN
  logic rr_last_q;

  // On a tie, the requester that was not granted last time wins.
  assign data_first = (rr_last_q == OWN_INST);

  // Remember the most recent winner for the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= OWN_INST;
    end else if (grant_data) begin
      rr_last_q <= OWN_DATA;
    end else if (grant_inst) begin
      rr_last_q <= OWN_INST;
    end
  end
`else
  assign data_first = 1'b1;
`endif

  // Grant decision. It is only made in IDLE, and a lone requester always wins.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (state_q == S_IDLE) begin
      grant_data = data_req && (!inst_req || data_first);
      grant_inst = inst_req && !grant_data;
    end
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;

  // The response goes to the owner only. The other requester never sees data_ok.
  assign inst_data_ok = (state_q == S_DATA) && bus_data_ok && (owner_q == OWN_INST);
  assign data_data_ok = (state_q == S_DATA) && bus_data_ok && (owner_q == OWN_DATA);

  assign inst_rdata = bus_rdata;
  assign data_rdata = bus_rdata;

  assign bus_req     = bus_req_q;
  assign bus_wr      = bus_wr_q;
  assign bus_size    = bus_size_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign dbg_state_o = state_q;

  // Transaction FSM. It latches the winner's request and holds it on the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_INST;
      bus_req_q   <= 1'b0;
      bus_wr_q    <= 1'b0;
      bus_size_q  <= 2'd0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_data) begin
            owner_q     <= OWN_DATA;
            bus_req_q   <= 1'b1;
            bus_wr_q    <= data_wr;
            bus_size_q  <= data_size;
            bus_addr_q  <= data_addr;
            bus_wdata_q <= data_wdata;
            state_q     <= S_ADDR;
          end else if (grant_inst) begin
            owner_q     <= OWN_INST;
            bus_req_q   <= 1'b1;
            bus_wr_q    <= 1'b0;
            bus_size_q  <= 2'd2;
            bus_addr_q  <= inst_addr;
            bus_wdata_q <= '0;
            state_q     <= S_ADDR;
          end else begin
            bus_req_q <= 1'b0;
          end
        end
        S_ADDR: begin
          if (bus_addr_ok) begin
            bus_req_q <= 1'b0;
            state_q   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bus_data_ok) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          bus_req_q <= 1'b0;
          state_q   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed and randomized transactions checked
// against a transaction-level model of the arbitration rule.
// The bench works the same whether or not ARB_RR_EN is defined.
module tb_sram_like_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W_INST = 0;
  localparam int W_DATA = 1;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req = 1'b0;
  logic          data_wr = 1'b0;
  logic [1:0]    data_size = 2'd0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_wdata = '0;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          bus_req, bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok = 1'b0;
  logic          bus_data_ok = 1'b0;
  logic [DW-1:0] bus_rdata = '0;
  logic [1:0]    dbg_state;

  int vectors = 0;
  int miscompares = 0;
  int last_win = W_INST;

  sram_like_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .dbg_state_o(dbg_state)
  );

  // clock and reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration rule: a lone requester wins. On a tie, data wins
  // (fixed), or the requester that did not win last time wins (round-robin).
  function automatic int pick(input bit i, input bit d, input int last);
    if (i && d) begin
`ifdef ARB_RR_EN
      return (last == W_INST) ? W_DATA : W_INST;
`else
      return W_DATA;
`endif
    end
    return d ? W_DATA : W_INST;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, dbg_state, ST_IDLE);
    check({tag, "_bus_req"}, bus_req, 1'b0);
    check({tag, "_bus_wr"}, bus_wr, 1'b0);
    check({tag, "_bus_size"}, bus_size, 2'd0);
    check({tag, "_bus_addr"}, bus_addr, '0);
    check({tag, "_bus_wdata"}, bus_wdata, '0);
  endtask

  // driver: one full transaction, starting in IDLE with the requests already driven
  task automatic run_txn(input int aw, input int dw, input bit glitch,
                         input bit allow_drop, input logic [DW-1:0] rd);
    int win;
    logic exp_wr;
    logic [1:0] exp_size;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
    @(negedge clk);
    win = pick(inst_req, data_req, last_win);
    last_win = win;
    check("grant_state", dbg_state, ST_IDLE);
    check("inst_addr_ok", inst_addr_ok, win == W_INST);
    check("data_addr_ok", data_addr_ok, win == W_DATA);
    if (win == W_DATA) begin
      exp_wr = data_wr; exp_size = data_size; exp_addr = data_addr; exp_wdata = data_wdata;
    end else begin
      exp_wr = 1'b0; exp_size = 2'd2; exp_addr = inst_addr; exp_wdata = '0;
    end
    @(posedge clk); #1;
    if (win == W_DATA) data_req = 1'b0; else inst_req = 1'b0;
    if (allow_drop && $urandom_range(0, 3) == 0) begin
      inst_req = 1'b0;
      data_req = 1'b0;
    end
    for (int i = 0; i <= aw; i++) begin
      bus_addr_ok = (i == aw);
      bus_data_ok = glitch && (i == 0) && (aw > 0);
      @(negedge clk);
      check("addr_state", dbg_state, ST_ADDR);
      check("addr_bus_req", bus_req, 1'b1);
      check("addr_bus_fields", {bus_wr, bus_size, bus_addr, bus_wdata},
            {exp_wr, exp_size, exp_addr, exp_wdata});
      check("addr_no_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
      check("addr_no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
      @(posedge clk); #1;
    end
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    for (int i = 0; i < dw; i++) begin
      @(negedge clk);
      check("data_wait_state", dbg_state, ST_DATA);
      check("data_wait_bus_req", bus_req, 1'b0);
      check("data_wait_no_ok", {inst_data_ok, data_data_ok, inst_addr_ok, data_addr_ok}, 4'b0);
      @(posedge clk); #1;
    end
    bus_rdata = rd;
    bus_data_ok = 1'b1;
    @(negedge clk);
    check("resp_bus_req", bus_req, 1'b0);
    check("resp_inst_data_ok", inst_data_ok, win == W_INST);
    check("resp_data_data_ok", data_data_ok, win == W_DATA);
    if (win == W_INST) check("resp_inst_rdata", inst_rdata, rd);
    else if (exp_wr == 1'b0) check("resp_data_rdata", data_rdata, rd);
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
  endtask

  task automatic raise_inst(input logic [AW-1:0] a);
    inst_req = 1'b1; inst_addr = a;
  endtask

  task automatic raise_data(input logic w, input logic [1:0] s,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
    data_req = 1'b1; data_wr = w; data_size = s; data_addr = a; data_wdata = d;
  endtask

  initial begin
    // reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // idle with no request: no grant, stay idle
    @(negedge clk);
    check("idle_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    check("idle_bus_req", bus_req, 1'b0);
    @(posedge clk); #1;
    check("idle_state", dbg_state, ST_IDLE);

    // fetch at the reset vector with a zero-wait slave
    raise_inst(32'hBFC0_0000);
    run_txn(0, 0, 1'b0, 1'b0, 32'h3C08_BFAF);

    // simultaneous LW and fetch: the model decides the order and the loser keeps its request
    raise_inst(32'hBFC0_0004);
    raise_data(1'b0, 2'd2, 32'h8000_1000, 32'h0);
    run_txn(0, 0, 1'b0, 1'b0, 32'h1234_5678);
    check("loser_still_pending", inst_req | data_req, 1'b1);
    run_txn(0, 1, 1'b0, 1'b0, 32'hCAFE_F00D);

    // store byte with a slave that stalls the address phase 4 cycles
    raise_data(1'b1, 2'd0, 32'h8000_0003, 32'h5A5A_5A5A);
    run_txn(4, 0, 1'b0, 1'b0, 32'h0);

    // both requesters stay active for 4 transactions
    for (int n = 0; n < 4; n++) begin
      inst_req = 1'b1;
      if (!data_req) raise_data(1'b0, 2'd2, 32'h8000_2000 + n * 4, 32'h0);
      run_txn(0, 0, 1'b0, 1'b0, $urandom);
    end
    inst_req = 1'b0;
    data_req = 1'b0;

    // bus_data_ok glitch while in ADDR is ignored
    raise_inst(32'hBFC0_0100);
    run_txn(2, 0, 1'b1, 1'b0, 32'h0BAD_0BAD);

    // reset while waiting for bus_data_ok
    raise_inst(32'hBFC0_0200);
    @(negedge clk);
    @(posedge clk); #1;
    inst_req = 1'b0;
    bus_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus_addr_ok = 1'b0;
    check("pre_reset_state", dbg_state, ST_DATA);
    #1 rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    bus_data_ok = 1'b1;
    @(negedge clk);
    check("mid_reset_no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    @(posedge clk); #1;
    bus_data_ok = 1'b0;
    #2 rst = 1'b0;
    last_win = W_INST;
    @(posedge clk); #1;
    raise_inst(32'hBFC0_0300);
    run_txn(1, 1, 1'b0, 1'b0, 32'h2468_ACE0);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (!inst_req && $urandom_range(0, 1) == 1)
        raise_inst($urandom & 32'hFFFF_FFFC);
      if (!data_req && $urandom_range(0, 1) == 1)
        raise_data($urandom_range(0, 1), $urandom_range(0, 2), $urandom, $urandom);
      if (!inst_req && !data_req) begin
        @(negedge clk);
        check("rand_idle_no_grant", {inst_addr_ok, data_addr_ok, bus_req}, 3'b000);
        @(posedge clk); #1;
        raise_inst($urandom & 32'hFFFF_FFFC);
      end
      run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1), 1'b1, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
